up_fetch: RTL and testbench

- Instruction fetch stage directly upstream of up_core.
- Holds the fetch PC and issues single-outstanding reads to program memory.
- Buffers returned words with their PC in a small prefetch FIFO and presents them to the core over a valid/ready handshake.
- Accepts branch/jump redirects from the core, flushing stale instructions.

---
 rtl/up_pkg.sv | 20 ++
 rtl/up_fetch_if.sv | 31 +++
 rtl/up_fetch_fifo.sv | 57 +++++
 rtl/up_fetch.sv | 131 +++++++++++++
 tb/tb_up_fetch.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/up_pkg.sv
// Shared definitions for the up_fetch / up_core pair: default bus widths,
// fetch FSM state encoding and the fetch-entry payload.
package up_pkg;

   localparam int unsigned DEF_ADDR_W  = 8;
   localparam int unsigned DEF_INSTR_W = 16;

   // IDLE: nothing outstanding, WAIT: outstanding and kept, DROP: outstanding and discarded
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0]  pc;
      logic [DEF_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/up_fetch_if.sv
// Fetch-stage bus bundle: program-memory read port, instruction handshake
// toward the core, and the redirect input from the core.
//   master : the fetch stage (drives mem_req/mem_addr and the instr_* outputs)
//   slave  : the memory + core side
interface up_fetch_if import up_pkg::*; #(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned INSTR_W = DEF_INSTR_W
);

   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_ack;
   logic [INSTR_W-1:0] mem_rdata;
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr_data;
   logic [ADDR_W-1:0]  instr_pc;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;

   modport master (
      output mem_req, mem_addr, instr_valid, instr_data, instr_pc,
      input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
   );

   modport slave (
      input  mem_req, mem_addr, instr_valid, instr_data, instr_pc,
      output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
   );

endinterface

// File: rtl/up_fetch_fifo.sv
// Small synchronous prefetch FIFO.
//   clk, rst_i      : clock, synchronous active-high reset (clears storage too)
//   push_i/push_data_i : write an entry at the tail
//   pop_i           : drop the head entry (ignored when empty)
//   flush_i         : discard all entries
//   count_o, valid_o, head_o : occupancy, non-empty flag, head entry
module up_fetch_fifo #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       valid_o,
   output logic [WIDTH-1:0]           head_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             pop_ok;

   assign pop_ok  = pop_i & (count_q != '0);
   assign count_o = count_q;
   assign valid_o = (count_q != '0);
   assign head_o  = mem_q[rd_ptr_q];

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/up_fetch.sv
// Instruction fetch stage: keeps the fetch PC, issues one outstanding read at
// a time to program memory, buffers returned words with their PC and hands
// them to the core over valid/ready. Redirects flush the buffer and retarget.
//   clk  : clock
//   nRst : synchronous, active-high reset
//   bus  : up_fetch_if.master (memory read port, instr handshake, redirect)
module up_fetch import up_pkg::*; #(
   parameter int unsigned      ADDR_W     = DEF_ADDR_W,
   parameter int unsigned      INSTR_W    = DEF_INSTR_W,
   parameter int unsigned      FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic      clk,
   input  logic      nRst,
   up_fetch_if.master bus
);

   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OCC_W   = CNT_W + 1;
   localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_req_q;

   logic [CNT_W-1:0]  occ;
   logic              fifo_valid;
   logic [ENTRY_W-1:0] head_raw;
   entry_t            head_entry;
   entry_t            push_entry;
   logic              push;
   logic              pop;
   logic [OCC_W-1:0]  occ_next;
   logic              has_space;
   logic [ADDR_W-1:0] fetch_pc_inc;

   // Occupancy after this cycle's push/pop decides whether to keep requesting
   always_comb begin
      pop          = fifo_valid & bus.instr_ready;
      push         = (state_q == WAIT) & bus.mem_ack & ~bus.redirect;
      occ_next     = OCC_W'(occ) + OCC_W'(push) - OCC_W'(pop);
      has_space    = (occ_next < OCC_W'(FIFO_DEPTH));
      fetch_pc_inc = fetch_pc_q + ADDR_W'(1);
      push_entry   = '{pc: fetch_pc_q, instr: bus.mem_rdata};
      head_entry   = entry_t'(head_raw);
   end

   up_fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_i       (nRst),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (bus.redirect),
      .count_o     (occ),
      .valid_o     (fifo_valid),
      .head_o      (head_raw)
   );

   // Request FSM; a request in flight can never be withdrawn, only its data dropped
   always_ff @(posedge clk) begin
      if (nRst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= RESET_PC;
      end else if (bus.redirect) begin
         fetch_pc_q <= bus.redirect_pc;
         if ((state_q == IDLE) || bus.mem_ack) begin
            state_q    <= WAIT;
            mem_req_q  <= 1'b1;
            mem_addr_q <= bus.redirect_pc;
         end else begin
            state_q <= DROP;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (occ < CNT_W'(FIFO_DEPTH)) begin
                  state_q    <= WAIT;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= fetch_pc_q;
               end
            end
            WAIT: begin
               if (bus.mem_ack) begin
                  fetch_pc_q <= fetch_pc_inc;
                  if (has_space) begin
                     mem_addr_q <= fetch_pc_inc;
                  end else begin
                     state_q   <= IDLE;
                     mem_req_q <= 1'b0;
                  end
               end
            end
            DROP: begin
               // fetch_pc already holds the redirect target
               if (bus.mem_ack) begin
                  if (has_space) begin
                     state_q    <= WAIT;
                     mem_addr_q <= fetch_pc_q;
                  end else begin
                     state_q   <= IDLE;
                     mem_req_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.instr_valid = fifo_valid;
   assign bus.instr_data  = head_entry.instr;
   assign bus.instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_up_fetch.sv
// Bench for up_fetch: memory model with configurable ack latency, a
// stream-based scoreboard (each reset/redirect starts a new expected PC stream)
// and directed scenarios followed by a randomized phase.
module tb_up_fetch;

   localparam int unsigned AW = 8;
   localparam int unsigned IW = 16;
   localparam logic [AW-1:0] RST_PC = 8'h00;

   typedef struct {
      int unsigned   epoch;
      logic [AW-1:0] pc;
      logic [IW-1:0] data;
   } exp_t;

   logic clk;
   logic nRst;

   up_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) ifc ();

   up_fetch #(
      .ADDR_W     (AW),
      .INSTR_W    (IW),
      .FIFO_DEPTH (2),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (ifc)
   );

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   int unsigned latest_epoch = 0;
   int unsigned cur_epoch = 0;
   int unsigned lat = 0;
   bit          rand_lat = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return IW'(16'h1000 + 16'(a));
   endfunction

   // Expected stream: consecutive addresses modulo 2^AW from the new start point
   task automatic push_epoch(input logic [AW-1:0] start);
      exp_t e;
      latest_epoch++;
      for (int i = 0; i < 256; i++) begin
         e.epoch = latest_epoch;
         e.pc    = AW'(int'(start) + i);
         e.data  = mem_word(e.pc);
         exp_q.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_redirect(input logic [AW-1:0] pc);
      ifc.redirect    = 1'b1;
      ifc.redirect_pc = pc;
      push_epoch(pc);
      tick();
      ifc.redirect = 1'b0;
   endtask

   task automatic reset_on(input int n);
      nRst = 1'b1;
      push_epoch(RST_PC);
      repeat (n) tick();
   endtask

   task automatic wait_mem(input logic [AW-1:0] a, input logic ack_v, input string name);
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (ifc.mem_req && ifc.mem_addr == a && ifc.mem_ack == ack_v) found = 1;
         else tick();
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=not_seen required=addr_%0h", name, a);
      end
   endtask

   // Memory: acks after cur_lat extra cycles; data is a fixed function of the address
   initial begin
      int unsigned cnt = 0;
      int unsigned cur_lat = 0;
      ifc.mem_ack   = 1'b0;
      ifc.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!ifc.mem_req) begin
            ifc.mem_ack = 1'b0;
            cnt = 0;
         end else begin
            if (cnt == 0) cur_lat = rand_lat ? $urandom_range(0, 3) : lat;
            if (cnt >= cur_lat) begin
               ifc.mem_ack   = 1'b1;
               ifc.mem_rdata = mem_word(ifc.mem_addr);
               cnt = 0;
            end else begin
               ifc.mem_ack = 1'b0;
               cnt++;
            end
         end
      end
   end

   // Monitor: request-hold protocol and scoreboard of accepted instructions
   initial begin
      logic          prev_req = 0;
      logic          prev_ack = 0;
      logic          prev_rst = 1;
      logic [AW-1:0] prev_addr = '0;
      exp_t          e;
      forever begin
         @(negedge clk);
         if (prev_req && !prev_ack && !prev_rst) begin
            check("req_hold", 32'(ifc.mem_req), 32'd1);
            check("addr_hold", 32'(ifc.mem_addr), 32'(prev_addr));
         end
         if (!nRst && ifc.instr_valid && ifc.instr_ready) begin
            while (exp_q.size() > 0 && exp_q[0].epoch < cur_epoch) void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow actual=pc_%0h required=no_instruction", ifc.instr_pc);
            end else begin
               e = exp_q.pop_front();
               check("instr_pc", 32'(ifc.instr_pc), 32'(e.pc));
               check("instr_data", 32'(ifc.instr_data), 32'(e.data));
            end
         end
         if (nRst || ifc.redirect) cur_epoch = latest_epoch;
         prev_req  = ifc.mem_req;
         prev_ack  = ifc.mem_ack;
         prev_rst  = nRst;
         prev_addr = ifc.mem_addr;
      end
   end

   initial begin
      logic [AW-1:0] got[4];
      int n;
      int last;
      bit found;

      nRst            = 1'b1;
      ifc.instr_ready = 1'b1;
      ifc.redirect    = 1'b0;
      ifc.redirect_pc = '0;

      // Reset values, then zero-wait streaming from RESET_PC
      reset_on(2);
      check("rst_mem_req", 32'(ifc.mem_req), 32'd0);
      check("rst_mem_addr", 32'(ifc.mem_addr), 32'(RST_PC));
      check("rst_valid", 32'(ifc.instr_valid), 32'd0);
      check("rst_data", 32'(ifc.instr_data), 32'd0);
      check("rst_pc", 32'(ifc.instr_pc), 32'd0);
      nRst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k <= 4) begin
            check("t1_req", 32'(ifc.mem_req), 32'd1);
            check("t1_addr", 32'(ifc.mem_addr), 32'(k - 1));
         end
         if (k >= 2) begin
            check("t1_valid", 32'(ifc.instr_valid), 32'd1);
            check("t1_ipc", 32'(ifc.instr_pc), 32'(k - 2));
            check("t1_idata", 32'(ifc.instr_data), 32'(16'h1000 + k - 2));
         end
      end

      // Backpressure: two entries buffered then requests stop
      reset_on(1);
      ifc.instr_ready = 1'b0;
      nRst = 1'b0;
      repeat (8) tick();
      check("bp_req_off", 32'(ifc.mem_req), 32'd0);
      check("bp_valid", 32'(ifc.instr_valid), 32'd1);
      check("bp_head_pc", 32'(ifc.instr_pc), 32'd0);
      ifc.instr_ready = 1'b1;
      repeat (12) tick();

      // Three-cycle memory: one ack every three cycles
      lat = 2;
      do_redirect(8'h10);
      n = 0;
      last = -1;
      for (int c = 0; c <= 30; c++) begin
         if (ifc.mem_req && ifc.mem_ack) begin
            if (last >= 0) check("ack_gap", 32'(c - last), 32'd3);
            last = c;
            n++;
         end
         tick();
      end
      check("ack_count", 32'(n), 32'd10);

      // Redirect while 0x05 outstanding, ack arrives later
      reset_on(1);
      nRst = 1'b0;
      wait_mem(8'h05, 1'b0, "wait_req5");
      do_redirect(8'h40);
      wait_mem(8'h05, 1'b1, "wait_ack5");
      tick();
      check("rd_next_req", 32'(ifc.mem_req), 32'd1);
      check("rd_next_addr", 32'(ifc.mem_addr), 32'h40);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (ifc.instr_valid) found = 1;
         else tick();
      end
      check("rd_first_valid", 32'(found), 32'd1);
      check("rd_first_pc", 32'(ifc.instr_pc), 32'h40);

      // Redirect coincident with ack
      wait_mem(8'h43, 1'b1, "wait_ack43");
      do_redirect(8'h80);
      check("rdack_req", 32'(ifc.mem_req), 32'd1);
      check("rdack_addr", 32'(ifc.mem_addr), 32'h80);
      repeat (10) tick();

      // Address wrap through 0xFF
      lat = 0;
      repeat (3) tick();
      do_redirect(8'hFE);
      n = 0;
      for (int i = 0; i < 20 && n < 4; i++) begin
         if (ifc.instr_valid) begin
            got[n] = ifc.instr_pc;
            n++;
         end
         tick();
      end
      check("wrap_cnt", 32'(n), 32'd4);
      check("wrap_pc0", 32'(got[0]), 32'hFE);
      check("wrap_pc1", 32'(got[1]), 32'hFF);
      check("wrap_pc2", 32'(got[2]), 32'h00);
      check("wrap_pc3", 32'(got[3]), 32'h01);

      // Reset pulse with data buffered and a request pending
      reset_on(1);
      ifc.instr_ready = 1'b0;
      lat = 3;
      nRst = 1'b0;
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (ifc.instr_valid && ifc.mem_req && !ifc.mem_ack) found = 1;
         else tick();
      end
      check("mid_setup", 32'(found), 32'd1);
      reset_on(1);
      check("mid_rst_req", 32'(ifc.mem_req), 32'd0);
      check("mid_rst_addr", 32'(ifc.mem_addr), 32'(RST_PC));
      check("mid_rst_valid", 32'(ifc.instr_valid), 32'd0);
      check("mid_rst_data", 32'(ifc.instr_data), 32'd0);
      check("mid_rst_pc", 32'(ifc.instr_pc), 32'd0);
      nRst = 1'b0;
      tick();
      check("mid_restart_req", 32'(ifc.mem_req), 32'd1);
      check("mid_restart_addr", 32'(ifc.mem_addr), 32'(RST_PC));
      ifc.instr_ready = 1'b1;
      lat = 0;
      repeat (10) tick();

      // Randomized traffic
      rand_lat = 1;
      for (int i = 0; i < 1500; i++) begin
         ifc.instr_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 499) == 0) begin
            reset_on(1);
            nRst = 1'b0;
         end else if ($urandom_range(0, 39) == 0) begin
            do_redirect(AW'($urandom_range(0, 255)));
         end else begin
            tick();
         end
      end
      ifc.instr_ready = 1'b1;
      repeat (10) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
